mem_port_arbiter: RTL

- Shares the single-port unified instruction/data memory between the fetch stage (reads only) and the memory stage (reads and writes).
- Serves one access at a time. Each access takes a fixed LATENCY cycles.
- Issues the memory command and returns data with a valid pulse.
- Drives stall_fetch and stall_mem so the hazard logic can freeze the pipeline while a requester waits.
- Sits between the fetch/memory stages and the memory macro.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the memory stage.
// Serves one fixed-latency access at a time; bounds memory-stage bursts so fetch cannot starve.
module mem_port_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int LATENCY       = 2,
    parameter int MAX_MEM_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              flush_fetch_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_valid_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              stall_fetch_o,
    output logic              stall_mem_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IF  = 2'd1,
        SERVE_MEM = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [3:0]        bcnt_q;
    logic              discard_q;
    logic              retire_q;
    logic              memWe_q;
    logic              ifValid_q;
    logic              memValid_q;
    logic [DATA_W-1:0] ifRdata_q;
    logic [DATA_W-1:0] memRdata_q;

    logic grantMem;
    logic grantIf;

    // The retire cycle (valid pulse) never issues: the requester still holds its old request there.
    always_comb begin
        grantMem = 1'b0;
        grantIf  = 1'b0;
        if (!rst_i && state_q == IDLE && !retire_q) begin
            if (mem_req_i && (!if_req_i || flush_fetch_i || bcnt_q < 4'(MAX_MEM_BURST))) begin
                grantMem = 1'b1;
            end else if (if_req_i && !flush_fetch_i) begin
                grantIf = 1'b1;
            end
        end
    end

    always_comb begin
        ram_en_o    = grantMem | grantIf;
        ram_we_o    = grantMem & mem_we_i;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (grantMem) begin
            ram_addr_o  = mem_addr_i;
            ram_wdata_o = mem_wdata_i;
        end else if (grantIf) begin
            ram_addr_o  = if_addr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            discard_q  <= 1'b0;
            retire_q   <= 1'b0;
            memWe_q    <= 1'b0;
            ifValid_q  <= 1'b0;
            memValid_q <= 1'b0;
            ifRdata_q  <= '0;
            memRdata_q <= '0;
        end else begin
            ifValid_q  <= 1'b0;
            memValid_q <= 1'b0;
            retire_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    discard_q <= 1'b0;
                    if (!if_req_i) begin
                        bcnt_q <= '0;
                    end
                    if (grantMem) begin
                        state_q <= SERVE_MEM;
                        cnt_q   <= 4'(LATENCY);
                        memWe_q <= mem_we_i;
                        if (if_req_i && !flush_fetch_i && bcnt_q != 4'd15) begin
                            bcnt_q <= bcnt_q + 4'd1;
                        end
                    end else if (grantIf) begin
                        state_q <= SERVE_IF;
                        cnt_q   <= 4'(LATENCY);
                        bcnt_q  <= '0;
                    end
                end
                SERVE_IF: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (flush_fetch_i) begin
                        discard_q <= 1'b1;
                    end
                    // A flushed fetch still completes in the memory but must never reach the fetch stage.
                    if (cnt_q == 4'd1) begin
                        state_q   <= IDLE;
                        retire_q  <= 1'b1;
                        discard_q <= 1'b0;
                        if (!discard_q && !flush_fetch_i) begin
                            ifValid_q <= 1'b1;
                            ifRdata_q <= ram_rdata_i;
                        end
                    end
                end
                SERVE_MEM: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q    <= IDLE;
                        retire_q   <= 1'b1;
                        memValid_q <= 1'b1;
                        memRdata_q <= memWe_q ? '0 : ram_rdata_i;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_valid_o    = ifValid_q;
    assign if_rdata_o    = ifRdata_q;
    assign mem_valid_o   = memValid_q;
    assign mem_rdata_o   = memRdata_q;
    assign busy_o        = (state_q != IDLE);
    assign stall_fetch_o = if_req_i & ~ifValid_q & ~flush_fetch_i;
    assign stall_mem_o   = mem_req_i & ~memValid_q;

endmodule
